// File: rtl/wm_pkg.sv
// Shared state encodings and width helpers for the wake-up-mission controller.
// Encodings 2 and 7 are deliberately unused and fall back to IDLE.
package wm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RING      = 3'd1,
        ST_WAIT      = 3'd3,
        ST_GOT_RIGHT = 3'd4,
        ST_GEN       = 3'd5,
        ST_SNOOZE    = 3'd6
    } state_t;

    localparam int STATE_W = 3;

    // Width of a counter that must hold 0..max_val (at least one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Width of the latched alarm source index.
    function automatic int id_w(input int n_sources);
        return $clog2(n_sources) + 1;
    endfunction

endpackage

// File: rtl/wm_cycle_timer.sv
// Clearable cycle counter that flags the last cycle of a LEN-cycle interval.
// Used for both the answer window and the snooze period.
module wm_cycle_timer #(
    parameter int LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int W = (LEN <= 2) ? 1 : $clog2(LEN);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= expire ? '0 : count_reg + 1'b1;
        end
    end

    // High on the LEN-th enabled cycle after a clear.
    assign expire = (count_reg == W'(LEN - 1));

endmodule

// File: rtl/wake_mission_ctrl.sv
// Wake-up-mission controller: arbitrates alarm sources, offers a bounded snooze
// and only clears the alarm after REQ_RIGHT correct puzzle answers.
module wake_mission_ctrl
    import wm_pkg::*;
#(
    parameter int N_ALARMS    = 2,
    parameter int REQ_RIGHT   = 3,
    parameter int TIMEOUT_CYC = 8,
    parameter int SNOOZE_CYC  = 16,
    parameter int MAX_SNOOZE  = 1,
    parameter int STREAK_MODE = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_ALARMS-1:0]            alarm_signal,
    input  logic                           alarm_switch,
    input  logic                           snooze_btn,
    input  logic                           answer_valid,
    input  logic                           answer_right,
    output logic                           alarm,
    output logic [$clog2(N_ALARMS):0]      alarm_id,
    output logic                           rng_req,
    output logic                           timer_enable,
    output logic [$clog2(REQ_RIGHT+1)-1:0] right_count,
    output logic                           mission_done,
    output logic                           snooze_active,
    output logic [STATE_W-1:0]             state
);

    localparam int ID_W  = id_w(N_ALARMS);
    localparam int CNT_W = cnt_w(REQ_RIGHT);
    localparam int SNZ_W = cnt_w(MAX_SNOOZE);

    state_t            state_reg;
    state_t            state_next;
    logic [CNT_W-1:0]  right_count_reg;
    logic [SNZ_W-1:0]  snz_used_reg;
    logic [ID_W-1:0]   alarm_id_reg;
    logic [ID_W-1:0]   sig_idx;
    logic              win_expire;
    logic              snz_expire;
    logic              snz_allowed;
    logic              at_goal;

    wm_cycle_timer #(.LEN(TIMEOUT_CYC)) u_window (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != ST_WAIT),
        .enable (state_reg == ST_WAIT),
        .expire (win_expire)
    );

    wm_cycle_timer #(.LEN(SNOOZE_CYC)) u_snooze (
        .clk    (clk),
        .rst    (rst),
        .clear  (state_reg != ST_SNOOZE),
        .enable (state_reg == ST_SNOOZE),
        .expire (snz_expire)
    );

    // Lowest asserted source wins when several match together.
    always_comb begin
        sig_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_signal[i]) sig_idx = ID_W'(i);
        end
    end

    assign snz_allowed = (int'(snz_used_reg) < MAX_SNOOZE);
    assign at_goal     = (right_count_reg == CNT_W'(REQ_RIGHT));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (alarm_switch && (|alarm_signal)) state_next = ST_RING;
            end
            ST_RING: begin
                if (!alarm_switch)                   state_next = ST_GEN;
                else if (snooze_btn && snz_allowed)  state_next = ST_SNOOZE;
            end
            ST_SNOOZE: begin
                if (snz_expire) state_next = ST_RING;
            end
            ST_GEN: begin
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // An answer on the final window cycle takes priority over the timeout.
                if (answer_valid)    state_next = answer_right ? ST_GOT_RIGHT : ST_GEN;
                else if (win_expire) state_next = ST_GEN;
            end
            ST_GOT_RIGHT: begin
                state_next = at_goal ? ST_IDLE : ST_GEN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            right_count_reg <= '0;
            snz_used_reg    <= '0;
            alarm_id_reg    <= '0;
        end else if (state_next == ST_IDLE) begin
            right_count_reg <= '0;
            snz_used_reg    <= '0;
            alarm_id_reg    <= '0;
        end else begin
            if (state_reg == ST_IDLE && state_next == ST_RING) begin
                alarm_id_reg <= sig_idx;
            end
            if (state_reg == ST_RING && state_next == ST_SNOOZE) begin
                snz_used_reg <= snz_used_reg + 1'b1;
            end
            if (state_reg == ST_WAIT && state_next == ST_GOT_RIGHT) begin
                if (!at_goal) right_count_reg <= right_count_reg + 1'b1;
            end else if (STREAK_MODE != 0 && state_reg == ST_WAIT && state_next == ST_GEN) begin
                right_count_reg <= '0;
            end
        end
    end

    always_comb begin
        alarm         = 1'b0;
        rng_req       = 1'b0;
        timer_enable  = 1'b0;
        mission_done  = 1'b0;
        snooze_active = 1'b0;
        state         = '0;
        case (state_reg)
            ST_RING: begin
                alarm = 1'b1;
                state = ST_RING;
            end
            ST_SNOOZE: begin
                snooze_active = 1'b1;
                state         = ST_SNOOZE;
            end
            ST_GEN: begin
                alarm   = 1'b1;
                rng_req = 1'b1;
                state   = ST_GEN;
            end
            ST_WAIT: begin
                alarm        = 1'b1;
                timer_enable = 1'b1;
                state        = ST_WAIT;
            end
            ST_GOT_RIGHT: begin
                alarm        = 1'b1;
                mission_done = at_goal;
                state        = ST_GOT_RIGHT;
            end
            default: begin
                state = '0;
            end
        endcase
    end

    assign right_count = right_count_reg;
    assign alarm_id    = alarm_id_reg;

endmodule

// File: tb/tb_wake_mission_ctrl.sv
// Bench for wake_mission_ctrl: a default instance and a STREAK_MODE=1 instance
// share stimulus and are checked every cycle against a behavioural model.
module tb_wake_mission_ctrl;

    localparam int REQ     = 3;
    localparam int TIMEOUT = 8;
    localparam int SNZ_LEN = 16;
    localparam int MAX_SNZ = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] sig;
    logic       sw, snz, av, ar;

    logic [2:0] st0, st1;
    logic [1:0] id0, id1, rc0, rc1;
    logic       al0, al1, rng0, rng1, ten0, ten1, dn0, dn1, sa0, sa1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    wake_mission_ctrl #(.STREAK_MODE(0)) u0 (
        .clk(clk), .rst(rst), .alarm_signal(sig), .alarm_switch(sw),
        .snooze_btn(snz), .answer_valid(av), .answer_right(ar),
        .alarm(al0), .alarm_id(id0), .rng_req(rng0), .timer_enable(ten0),
        .right_count(rc0), .mission_done(dn0), .snooze_active(sa0), .state(st0)
    );

    wake_mission_ctrl #(.STREAK_MODE(1)) u1 (
        .clk(clk), .rst(rst), .alarm_signal(sig), .alarm_switch(sw),
        .snooze_btn(snz), .answer_valid(av), .answer_right(ar),
        .alarm(al1), .alarm_id(id1), .rng_req(rng1), .timer_enable(ten1),
        .right_count(rc1), .mission_done(dn1), .snooze_active(sa1), .state(st1)
    );

    // Packed view: {state, alarm, id, rng_req, timer_enable, right_count, done, snooze}
    logic [11:0] obs0, obs1;
    assign obs0 = {st0, al0, id0, rng0, ten0, rc0, dn0, sa0};
    assign obs1 = {st1, al1, id1, rng1, ten1, rc1, dn1, sa1};

    // Behavioural model: phase (numeric state code) plus elapsed-cycle counters.
    int m_st[2], m_rc[2], m_snz[2], m_id[2], m_win[2], m_sc[2];

    function automatic logic [11:0] model_out(input int k);
        logic [2:0] s;
        logic [1:0] rc, id;
        s  = 3'(m_st[k]);
        rc = 2'(m_rc[k]);
        id = 2'(m_id[k]);
        return {s, 1'(m_st[k] == 1 || m_st[k] == 3 || m_st[k] == 4 || m_st[k] == 5), id,
                1'(m_st[k] == 5), 1'(m_st[k] == 3), rc,
                1'(m_st[k] == 4 && m_rc[k] == REQ), 1'(m_st[k] == 6)};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_rc[k] = 0; m_snz[k] = 0; m_id[k] = 0; m_win[k] = 0; m_sc[k] = 0;
        end
    endtask

    task automatic model_tick(input int k, input int streak);
        case (m_st[k])
            0: if (sw && (sig != 2'b00)) begin
                m_st[k] = 1;
                m_id[k] = sig[0] ? 0 : 1;
            end
            1: if (!sw) m_st[k] = 5;
               else if (snz && m_snz[k] < MAX_SNZ) begin
                   m_st[k] = 6; m_snz[k]++; m_sc[k] = 0;
               end
            6: begin
                m_sc[k]++;
                if (m_sc[k] == SNZ_LEN) m_st[k] = 1;
            end
            5: begin m_win[k] = 0; m_st[k] = 3; end
            3: begin
                m_win[k]++;
                if (av && ar) begin
                    m_st[k] = 4;
                    if (m_rc[k] < REQ) m_rc[k]++;
                end else if (av || m_win[k] == TIMEOUT) begin
                    m_st[k] = 5;
                    if (streak != 0) m_rc[k] = 0;
                end
            end
            4: m_st[k] = (m_rc[k] == REQ) ? 0 : 5;
            default: m_st[k] = 0;
        endcase
        if (m_st[k] == 0) begin m_rc[k] = 0; m_snz[k] = 0; m_id[k] = 0; end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    logic        tab_en = 1'b0;
    logic [11:0] tab_exp;

    // One clock cycle: apply inputs, compare before the edge, advance model on the edge.
    task automatic step(input logic [1:0] s, input logic w, input logic n,
                        input logic v, input logic r);
        sig = s; sw = w; snz = n; av = v; ar = r;
        @(negedge clk);
        chk("model_u0", 32'(obs0), 32'(model_out(0)));
        chk("model_u1", 32'(obs1), 32'(model_out(1)));
        if (tab_en) chk("table_u0", 32'(obs0), 32'(tab_exp));
        @(posedge clk);
        model_tick(0, 0);
        model_tick(1, 1);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic answer(input logic r);
        step(2'b00, 1'b0, 1'b0, 1'b1, r);
    endtask

    // From IDLE: ring on source pattern s, drop the switch, land in WAIT.
    task automatic go_wait(input logic [1:0] s);
        step(s, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic do_reset();
        sig = '0; sw = 0; snz = 0; av = 0; ar = 0;
        rst = 1'b1;
        #3;
        chk("reset_async_u0", 32'(obs0), 32'h0);
        chk("reset_async_u1", 32'(obs1), 32'h0);
        model_reset();
        @(posedge clk); #1;
        chk("reset_hold_u0", 32'(obs0), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [1:0]  sig;
        logic        sw, snz, av, ar;
        logic [11:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] s, input logic w, input logic v,
                                input logic r, input logic [2:0] est, input logic [1:0] eid,
                                input logic [1:0] erc);
        vec_t t;
        t.sig = s; t.sw = w; t.snz = 1'b0; t.av = v; t.ar = r;
        t.exp = {est, 1'(est == 1 || est == 3 || est == 4 || est == 5), eid,
                 1'(est == 5), 1'(est == 3), erc, 1'(est == 4 && erc == 2'd3), 1'b0};
        return t;
    endfunction

    vec_t tab[13];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Basic mission: source 1 rings, three right answers clear it.
        tab[0]  = mk(2'b10, 1, 0, 0, 3'd0, 2'd0, 2'd0);
        tab[1]  = mk(2'b00, 1, 0, 0, 3'd1, 2'd1, 2'd0);
        tab[2]  = mk(2'b00, 0, 0, 0, 3'd1, 2'd1, 2'd0);
        tab[3]  = mk(2'b00, 0, 0, 0, 3'd5, 2'd1, 2'd0);
        tab[4]  = mk(2'b00, 0, 1, 1, 3'd3, 2'd1, 2'd0);
        tab[5]  = mk(2'b00, 0, 0, 0, 3'd4, 2'd1, 2'd1);
        tab[6]  = mk(2'b00, 0, 0, 0, 3'd5, 2'd1, 2'd1);
        tab[7]  = mk(2'b00, 0, 1, 1, 3'd3, 2'd1, 2'd1);
        tab[8]  = mk(2'b00, 0, 0, 0, 3'd4, 2'd1, 2'd2);
        tab[9]  = mk(2'b00, 0, 0, 0, 3'd5, 2'd1, 2'd2);
        tab[10] = mk(2'b00, 0, 1, 1, 3'd3, 2'd1, 2'd2);
        tab[11] = mk(2'b00, 0, 0, 0, 3'd4, 2'd1, 2'd3);
        tab[12] = mk(2'b00, 0, 0, 0, 3'd0, 2'd0, 2'd0);

        do_reset();

        tab_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            tab_exp = tab[i].exp;
            step(tab[i].sig, tab[i].sw, tab[i].snz, tab[i].av, tab[i].ar);
        end
        tab_en = 1'b0;

        // Wrong answer and window timeout both count as wrong.
        go_wait(2'b01);
        answer(1'b1);
        chk("wt_rc_after_right", 32'(rc0), 32'd1);
        idle(2);
        answer(1'b0);
        chk("wt_rc_after_wrong", 32'(rc0), 32'd1);
        idle(1);
        idle(TIMEOUT);
        chk("wt_timeout_to_gen", 32'(st0), 32'd5);
        chk("wt_rc_after_timeout", 32'(rc0), 32'd1);
        idle(1);
        answer(1'b1);
        chk("wt_rc_two", 32'(rc0), 32'd2);
        idle(2);
        answer(1'b1);
        chk("wt_done_pulse", 32'(dn0), 32'd1);
        idle(1);
        chk("wt_back_idle", 32'(st0), 32'd0);

        do_reset();

        // Snooze: 16 quiet cycles, second press ignored, switch beats snooze.
        step(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("snz_entered", 32'(sa0), 32'd1);
        for (int i = 0; i < SNZ_LEN - 1; i++) step(2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("snz_still_quiet", 32'({sa0, al0}), 32'b10);
        step(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("snz_back_ring", 32'({st0, al0}), 32'({3'd1, 1'b1}));
        step(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("snz_second_ignored", 32'(st0), 32'd1);
        step(2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("snz_switch_wins", 32'(st0), 32'd5);
        idle(1);

        // Right answer on the final window cycle beats the timeout.
        idle(TIMEOUT - 1);
        answer(1'b1);
        chk("edge_answer_wins", 32'(st0), 32'd4);
        chk("edge_answer_rc", 32'(rc0), 32'd1);
        idle(2);
        answer(1'b1);
        idle(2);
        chk("rst_pre_rc", 32'(rc0), 32'd2);

        // Asynchronous abort from WAIT with two rights banked.
        do_reset();

        go_wait(2'b11);
        chk("id_lowest_wins", 32'(id0), 32'd0);
        answer(1'b1); idle(2);
        answer(1'b1); idle(2);
        chk("post_rst_not_done", 32'(st0), 32'd3);
        answer(1'b1);
        chk("post_rst_done", 32'(dn0), 32'd1);
        idle(1);

        // Streak mode: a wrong answer forfeits banked rights.
        go_wait(2'b01);
        answer(1'b1); idle(2);
        answer(1'b1); idle(2);
        answer(1'b0);
        chk("streak_cleared", 32'(rc1), 32'd0);
        chk("nostreak_kept", 32'(rc0), 32'd2);
        idle(1);
        answer(1'b1); idle(2);
        answer(1'b1); idle(2);
        chk("streak_not_yet", 32'(dn1), 32'd0);
        answer(1'b1);
        chk("streak_done", 32'(dn1), 32'd1);
        idle(2);

        do_reset();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] s;
            s = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            step(s, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
